// File: rtl/rt_port_tx.sv
// Router port transmitter: queues local words in a FIFO and sends each one as a
// two-phase req/ack packet. Optional ack timeout monitor enabled by RT_TX_TIMEOUT_EN.
module rt_port_tx #(
   parameter int N              = 32,
   parameter int X_BITS         = 1,
   parameter int Y_BITS         = 1,
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [X_BITS-1:0]          in_dst_x,
   input  logic [Y_BITS-1:0]          in_dst_y,
   input  logic [N-1:0]               in_payload,
   output logic                       req_o,
   output logic [N+X_BITS+Y_BITS-1:0] data_o,
   input  logic                       ack_i,
   output logic                       busy,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       timeout_err
);

   localparam int W  = N + X_BITS + Y_BITS;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK} state_t;

   state_t         state, next_state;
   logic [W-1:0]   mem [DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic           ack_m, ack_s;
   logic           full, empty, push, pop, load, toggle;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign in_ready = !rst && !full;
   assign push     = in_valid && in_ready;
   assign busy     = !rst && ((state != IDLE) || !empty);

   always_ff @(posedge clk) begin
      if (rst) begin
         ack_m <= 1'b0;
         ack_s <= 1'b0;
      end else begin
         ack_m <= ack_i;
         ack_s <= ack_m;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      load       = 1'b0;
      toggle     = 1'b0;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               load       = 1'b1;
               next_state = LOAD;
            end
         end
         LOAD: begin
            toggle     = 1'b1;
            next_state = WAIT_ACK;
         end
         WAIT_ACK: begin
            // Head stays queued until the peer acknowledges it.
            if (ack_s == req_o) begin
               pop        = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[AW'(i)] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         req_o  <= 1'b0;
         data_o <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {in_dst_x, in_dst_y, in_payload};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop)    rd_ptr <= rd_ptr + 1'b1;
         if (load)   data_o <= mem[rd_ptr];
         if (toggle) req_o  <= ~req_o;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef RT_TX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tcnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         tcnt        <= '0;
         timeout_err <= 1'b0;
      end else if (state == WAIT_ACK && !pop) begin
         if (tcnt != TW'(TIMEOUT_CYCLES)) tcnt <= tcnt + 1'b1;
         if (tcnt + 1'b1 == TW'(TIMEOUT_CYCLES)) timeout_err <= 1'b1;
      end else begin
         tcnt <= '0;
      end
   end
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_rt_port_tx.sv
// Self-checking bench for rt_port_tx: directed vectors plus randomized traffic
// against a queue-based reference of the FIFO and handshake.
module tb_rt_port_tx;

   localparam int N     = 32;
   localparam int XB    = 1;
   localparam int YB    = 1;
   localparam int DEPTH = 4;
   localparam int TO    = 8;
   localparam int W     = N + XB + YB;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [XB-1:0] in_dst_x = '0;
   logic [YB-1:0] in_dst_y = '0;
   logic [N-1:0]  in_payload = '0;
   logic          req_o;
   logic [W-1:0]  data_o;
   logic          ack_i = 1'b0;
   logic          busy;
   logic [CW-1:0] count;
   logic          timeout_err;

   always #5 clk = ~clk;

   rt_port_tx #(.N(N), .X_BITS(XB), .Y_BITS(YB), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_dst_x(in_dst_x), .in_dst_y(in_dst_y), .in_payload(in_payload),
      .req_o(req_o), .data_o(data_o), .ack_i(ack_i), .busy(busy),
      .count(count), .timeout_err(timeout_err)
   );

   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] exp_q[$];
   int           pop_in = 0;
   bit           ack_pending = 1'b0;
   int           ack_wait = 0;
   bit           auto_ack = 1'b0;
   logic         last_req = 1'b0;

   typedef struct {
      logic         valid;
      logic [N-1:0] payload;
      logic         exp_ready;
      int           exp_count;
   } vec_t;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One clock: reference update at the edge, DUT compared 1 ns later.
   // A peer ack becomes a pop three edges later (two sync flops, then the match).
   task automatic tick();
      bit p = 1'b0;
      @(posedge clk);
      if (rst) begin
         exp_q.delete();
         pop_in      = 0;
         ack_pending = 1'b0;
         last_req    = 1'b0;
      end else begin
         if (pop_in > 0) begin
            pop_in--;
            if (pop_in == 0) p = 1'b1;
         end
         if (in_valid && exp_q.size() < DEPTH) exp_q.push_back({in_dst_x, in_dst_y, in_payload});
         if (p) void'(exp_q.pop_front());
      end
      #1;
      check("count", count, exp_q.size());
      check("in_ready", in_ready, !rst && exp_q.size() < DEPTH);
      check("busy", busy, !rst && exp_q.size() != 0);
      if (!rst && req_o !== last_req) begin
         last_req = req_o;
         check("req_has_pkt", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) check("req_data", data_o, exp_q[0]);
         ack_pending = 1'b1;
         ack_wait    = $urandom_range(0, 4);
      end
      if (auto_ack && ack_pending) begin
         if (ack_wait == 0) begin
            ack_i       = req_o;
            pop_in      = 3;
            ack_pending = 1'b0;
         end else begin
            ack_wait--;
         end
      end
   endtask

   task automatic push(input logic [XB-1:0] x, input logic [YB-1:0] y, input logic [N-1:0] p);
      in_dst_x   = x;
      in_dst_y   = y;
      in_payload = p;
      in_valid   = 1'b1;
      tick();
      in_valid   = 1'b0;
   endtask

   task automatic do_ack(input string nm, input logic [W-1:0] exp);
      for (int i = 0; i < 20 && !ack_pending; i++) tick();
      check({nm, "_req"}, ack_pending, 1);
      check({nm, "_data"}, data_o, exp);
      if (ack_pending) begin
         ack_i       = req_o;
         pop_in      = 3;
         ack_pending = 1'b0;
      end
   endtask

   task automatic drain(input string nm);
      for (int i = 0; i < 200 && (exp_q.size() != 0 || busy); i++) begin
         if (!auto_ack && ack_pending) begin
            ack_i       = req_o;
            pop_in      = 3;
            ack_pending = 1'b0;
         end
         tick();
      end
      check({nm, "_count"}, count, 0);
      check({nm, "_busy"}, busy, 0);
      check({nm, "_model_empty"}, exp_q.size(), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t fill[5];
      fill[0] = '{1'b1, 32'd0, 1'b1, 1};
      fill[1] = '{1'b1, 32'd1, 1'b1, 2};
      fill[2] = '{1'b1, 32'd2, 1'b1, 3};
      fill[3] = '{1'b1, 32'd3, 1'b0, 4};
      fill[4] = '{1'b1, 32'd4, 1'b0, 4};

      // Reset state
      rst = 1'b1;
      repeat (3) tick();
      check("rst_req", req_o, 0);
      check("rst_data", data_o, 0);
      check("rst_count", count, 0);
      check("rst_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_terr", timeout_err, 0);
      rst = 1'b0;
      tick();

      // Single packet: data valid after T+1, req toggles at T+2
      push(1'b0, 1'b1, 32'hFFFF_FFFF);
      check("single_t0_req", req_o, 0);
      tick();
      check("single_t1_data", data_o, 34'h1_FFFF_FFFF);
      check("single_t1_req", req_o, 0);
      tick();
      check("single_t2_req", req_o, 1);
      repeat (10) tick();
      check("single_hold_count", count, 1);
      do_ack("single", 34'h1_FFFF_FFFF);
      drain("single");
      check("single_data_stable", data_o, 34'h1_FFFF_FFFF);

      // Fill with ack held, then release in order
      for (int i = 0; i < 5; i++) begin
         in_dst_x   = '0;
         in_dst_y   = '0;
         in_valid   = fill[i].valid;
         in_payload = fill[i].payload;
         tick();
         check("fill_count", count, fill[i].exp_count);
         check("fill_ready", in_ready, fill[i].exp_ready);
      end
      in_valid = 1'b0;
      repeat (3) tick();
      check("fill_held", count, 4);
      for (int i = 0; i < 4; i++) do_ack("fill_order", W'(i));
      drain("fill");

      // Simultaneous push/pop at count 2, then pointer wrap over 6 packets
      push('0, '0, 32'd10);
      push('0, '0, 32'd11);
      do_ack("pp_a", 34'd10);
      check("pp_pre", count, 2);
      tick();
      tick();
      push('0, '0, 32'd12);
      check("pp_count", count, 2);
      push('0, '0, 32'd13);
      push('0, '0, 32'd14);
      check("wrap_full", count, 4);
      for (int i = 11; i <= 14; i++) do_ack("wrap_order", W'(i));
      push('0, '0, 32'd15);
      do_ack("wrap_last", 34'd15);
      drain("wrap");

      // Ack timeout
      push('0, '0, 32'h77);
      for (int i = 0; i < 10 && !ack_pending; i++) tick();
      repeat (7) tick();
      check("to_early", timeout_err, 0);
      tick();
`ifdef RT_TX_TIMEOUT_EN
      check("to_set", timeout_err, 1);
      repeat (10) tick();
      check("to_hold", timeout_err, 1);
      do_ack("to_late", 34'h77);
      drain("to");
      check("to_sticky", timeout_err, 1);
`else
      check("to_off", timeout_err, 0);
      repeat (10) tick();
      check("to_off_hold", timeout_err, 0);
      do_ack("to_late", 34'h77);
      drain("to");
`endif

      // Reset during WAIT_ACK
      push('0, '0, 32'hA5);
      tick();
      tick();
      check("mid_pending", ack_pending, 1);
      rst   = 1'b1;
      ack_i = 1'b0;
      tick();
      check("mid_req", req_o, 0);
      check("mid_data", data_o, 0);
      check("mid_count", count, 0);
      check("mid_ready", in_ready, 0);
      check("mid_busy", busy, 0);
      check("mid_terr", timeout_err, 0);
      rst = 1'b0;
      tick();
      check("mid_idle", busy, 0);
      push(1'b1, 1'b0, 32'h5A);
      do_ack("mid_after", {1'b1, 1'b0, 32'h5A});
      drain("mid");

      // Randomized traffic with randomized ack delay
      auto_ack = 1'b1;
      for (int i = 0; i < 400; i++) begin
         in_valid   = ($urandom_range(0, 1) == 1);
         in_dst_x   = XB'($urandom);
         in_dst_y   = YB'($urandom);
         in_payload = $urandom;
         tick();
      end
      in_valid = 1'b0;
      drain("rand");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
